// File: rtl/ibuffer_pack.sv
// ibuffer_pack: packs Avalon-ST flits MSB-first into multi-flit words and queues them in a show-ahead FIFO.
// Latency: a word is written in the cycle its last flit (or eop) is accepted and is visible on o_data one cycle later.
// Backpressure: o_ready = !full (also low for the one cycle a deferred restart word is flushed); i_ready holds the head word.
module ibuffer_pack #(
  parameter int DATA_WIDTH     = 64,
  parameter int FLITS_PER_WORD = 2,
  parameter int DEST_WIDTH     = 4,
  parameter int DEPTH          = 256,
  localparam int FLIT_W        = DATA_WIDTH + 7,
  localparam int WORD_W        = FLITS_PER_WORD * FLIT_W,
  localparam int CW            = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic                  i_error,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [2:0]            i_empty,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [WORD_W-1:0]     o_data,
  output logic [DEST_WIDTH-1:0] o_dest,
  input  logic                  i_ready,
  output logic [CW-1:0]         o_space_left,
  output logic [CW-1:0]         o_pkt_count,
  output logic                  o_proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (FLITS_PER_WORD > 1) ? $clog2(FLITS_PER_WORD) : 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              eop_mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d, pkt_q, pkt_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              open_q, open_d;
  logic              err_q, err_d;
  // A sop+eop flit that restarts a partial word needs a second write; it waits one cycle in asm_q.
  logic              flush_q, flush_d;

  logic [FLIT_W-1:0] flit;
  logic [WORD_W-1:0] slot0_word, placed, wr_word;
  logic              full, accept, wr_en, wr_eop, rd_en;

  assign full         = (count_q == CW'(DEPTH));
  assign o_ready      = !full && !flush_q;
  assign o_valid      = (count_q != '0);
  assign o_data       = mem_q[rd_ptr_q];
  assign o_dest       = o_data[WORD_W-8 -: DEST_WIDTH];
  assign o_space_left = CW'(DEPTH) - count_q;
  assign o_pkt_count  = pkt_q;
  assign o_proto_err  = err_q;
  assign rd_en        = o_valid && i_ready;

  // Flit assembly, protocol checking and FIFO bookkeeping.
  always_comb begin
    flit       = {1'b1, i_sop, i_eop, i_empty, i_error, i_data};
    slot0_word = '0;
    slot0_word[WORD_W-1 -: FLIT_W] = flit;
    placed     = asm_q;
    for (int s = 0; s < FLITS_PER_WORD; s++) begin
      if (slot_q == SW'(s)) placed[WORD_W-1-s*FLIT_W -: FLIT_W] = flit;
    end
    accept  = i_valid && o_ready;
    wr_en   = 1'b0;
    wr_eop  = 1'b0;
    wr_word = '0;
    asm_d   = asm_q;
    slot_d  = slot_q;
    open_d  = open_q;
    err_d   = err_q;
    flush_d = flush_q;
    if (flush_q) begin
      if (!full) begin
        wr_en   = 1'b1;
        wr_word = asm_q;
        wr_eop  = 1'b1;
        asm_d   = '0;
        flush_d = 1'b0;
      end
    end else if (accept) begin
      open_d = !i_eop;
      if (i_sop && slot_q != '0) begin
        // Missing eop: push out the partial word and restart in slot 0.
        err_d   = 1'b1;
        wr_en   = 1'b1;
        wr_word = asm_q;
        asm_d   = slot0_word;
        if (i_eop) begin
          flush_d = 1'b1;
          slot_d  = '0;
        end else begin
          slot_d  = SW'(1);
        end
      end else begin
        if (!i_sop && slot_q == '0 && !open_q) err_d = 1'b1;
        if (i_eop || slot_q == SW'(FLITS_PER_WORD - 1)) begin
          wr_en   = 1'b1;
          wr_word = placed;
          wr_eop  = i_eop;
          asm_d   = '0;
          slot_d  = '0;
        end else begin
          asm_d   = placed;
          slot_d  = slot_q + SW'(1);
        end
      end
    end
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    pkt_d    = pkt_q + CW'(wr_en && wr_eop) - CW'(rd_en && eop_mem_q[rd_ptr_q]);
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pkt_q    <= '0;
      slot_q   <= '0;
      asm_q    <= '0;
      open_q   <= 1'b0;
      err_q    <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pkt_q    <= pkt_d;
      slot_q   <= slot_d;
      asm_q    <= asm_d;
      open_q   <= open_d;
      err_q    <= err_d;
      flush_q  <= flush_d;
    end
  end

  // Word storage; entries are only visible through occupancy so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q]     <= wr_word;
      eop_mem_q[wr_ptr_q] <= wr_eop;
    end
  end

endmodule
